fx_mac_seq: RTL

Sequencer for the fixed-point MAC datapath: streams K weight/data pairs per output from two synchronous-read buffers into the MAC, collects each result and writes it to an output buffer. It computes `cfg_n` outputs per command, one K-tap window per output, with a programmable data stride. It sits between the layer control FSM (start/done) and one MAC instance plus its buffers.

---
 rtl/fx_mac_pkg.sv | 27 ++
 rtl/fx_mac_seq_if.sv | 32 +++
 rtl/fx_mac_agen.sv | 50 +++++
 rtl/fx_mac_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fx_mac_pkg.sv
// Shared types and defaults for the MAC sequencer slice.
package fx_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_WRITE,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_K       = 9;
    localparam int DEF_AW      = 10;
    localparam int DEF_CW      = 8;
    localparam int DEF_GAP     = 6;
    localparam int DEF_TIMEOUT = 32;

    // Depth of the MAC's valid history; fewer idle cycles would not clear its accumulator.
    localparam int VLD_HIST = 5;

    function automatic int gap_cycles(input int gap);
        return (gap < VLD_HIST) ? VLD_HIST : gap;
    endfunction

endpackage

// File: rtl/fx_mac_seq_if.sv
// Buffer read/write and MAC operand/result signals between the sequencer and its datapath.
interface fx_mac_seq_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 10
);
    logic             w_ren;
    logic             d_ren;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    d_addr;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] d_rdata;
    logic [WIDTH-1:0] mac_win;
    logic [WIDTH-1:0] mac_din;
    logic             mac_vld;
    logic [WIDTH-1:0] mac_acc;
    logic             mac_vld_o;
    logic             o_we;
    logic [AW-1:0]    o_addr;
    logic [WIDTH-1:0] o_wdata;

    modport master (
        output w_ren, d_ren, w_addr, d_addr, mac_win, mac_din, mac_vld,
               o_we, o_addr, o_wdata,
        input  w_rdata, d_rdata, mac_acc, mac_vld_o
    );

    modport slave (
        input  w_ren, d_ren, w_addr, d_addr, mac_win, mac_din, mac_vld,
               o_we, o_addr, o_wdata,
        output w_rdata, d_rdata, mac_acc, mac_vld_o
    );
endinterface

// File: rtl/fx_mac_agen.sv
// Tap/window counters and the weight, data and output address adders.
module fx_mac_agen #(
    parameter int K  = 9,
    parameter int AW = 10,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          k_step,
    input  logic          j_step,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] d_base,
    input  logic [AW-1:0] o_base,
    input  logic [AW-1:0] d_stride,
    input  logic [CW-1:0] n,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] d_addr,
    output logic [AW-1:0] o_addr,
    output logic          k_last,
    output logic          j_last
);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [KW-1:0] k_q;
    logic [CW-1:0] j_q;
    logic [AW-1:0] row_q;

    // row_q tracks j*stride incrementally so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k_q   <= '0;
            j_q   <= '0;
            row_q <= '0;
        end else if (j_step) begin
            k_q   <= '0;
            j_q   <= j_q + CW'(1);
            row_q <= row_q + d_stride;
        end else if (k_step) begin
            k_q <= k_q + KW'(1);
        end
    end

    assign k_last = (k_q == KW'(K - 1));
    assign j_last = (j_q == n - CW'(1));
    assign w_addr = w_base + AW'(k_q);
    assign d_addr = d_base + row_q + AW'(k_q);
    assign o_addr = o_base + AW'(j_q);

endmodule

// File: rtl/fx_mac_seq.sv
// Streams K-tap windows into the MAC and writes one result per window to the output buffer.
//
//  state | meaning
//  IDLE  | waiting for start
//  FEED  | K cycles of weight/data reads
//  WAIT  | waiting for mac_vld_o, bounded by TIMEOUT
//  WRITE | one output buffer write of the captured result
//  GAP   | idle cycles so the MAC accumulator clears
//  DONE  | one-cycle done pulse
module fx_mac_seq
    import fx_mac_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int K       = DEF_K,
    parameter int AW      = DEF_AW,
    parameter int CW      = DEF_CW,
    parameter int GAP     = DEF_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_d_base,
    input  logic [AW-1:0] cfg_o_base,
    input  logic [AW-1:0] cfg_d_stride,
    input  logic [CW-1:0] cfg_n,
    output logic          busy,
    output logic          done,
    output logic          err,
    fx_mac_seq_if.master  bus
);
    localparam int GAP_C = gap_cycles(GAP);
    localparam int TMAX  = (TIMEOUT > GAP_C) ? TIMEOUT : GAP_C;
    localparam int TW    = $clog2(TMAX + 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    w_base_q, d_base_q, o_base_q, stride_q;
    logic [CW-1:0]    n_q;
    logic [TW-1:0]    tmr_q;
    logic             err_q;
    logic             vld_q;
    logic [WIDTH-1:0] res_q;

    logic             accept, feed, wr;
    logic             k_step, j_step, ld_wait, ld_gap, timeout, capture;
    logic             k_last, j_last, tmr_zero;
    logic [AW-1:0]    w_addr_a, d_addr_a, o_addr_a;

    assign accept   = (state_q == ST_IDLE) && start;
    assign tmr_zero = (tmr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        k_step  = 1'b0;
        j_step  = 1'b0;
        ld_wait = 1'b0;
        ld_gap  = 1'b0;
        timeout = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = (cfg_n == '0) ? ST_DONE : ST_FEED;
            ST_FEED: begin
                if (k_last) begin
                    state_d = ST_WAIT;
                    ld_wait = 1'b1;
                end else begin
                    k_step = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mac_vld_o) begin
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end else if (tmr_zero) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                state_d = ST_GAP;
                ld_gap  = 1'b1;
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (j_last) begin
                        state_d = ST_DONE;
                    end else begin
                        j_step  = 1'b1;
                        state_d = ST_FEED;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // One down-counter serves both the WAIT timeout and the GAP length.
    always_ff @(posedge clk) begin
        if (rst)               tmr_q <= '0;
        else if (ld_wait)      tmr_q <= TW'(TIMEOUT - 1);
        else if (ld_gap)       tmr_q <= TW'(GAP_C - 1);
        else if (!tmr_zero)    tmr_q <= tmr_q - TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_base_q <= '0;
            d_base_q <= '0;
            o_base_q <= '0;
            stride_q <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                w_base_q <= cfg_w_base;
                d_base_q <= cfg_d_base;
                o_base_q <= cfg_o_base;
                stride_q <= cfg_d_stride;
                n_q      <= cfg_n;
                err_q    <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
            vld_q <= feed;
            if (capture) res_q <= bus.mac_acc;
        end
    end

    fx_mac_agen #(.K(K), .AW(AW), .CW(CW)) u_agen (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .k_step   (k_step),
        .j_step   (j_step),
        .w_base   (w_base_q),
        .d_base   (d_base_q),
        .o_base   (o_base_q),
        .d_stride (stride_q),
        .n        (n_q),
        .w_addr   (w_addr_a),
        .d_addr   (d_addr_a),
        .o_addr   (o_addr_a),
        .k_last   (k_last),
        .j_last   (j_last)
    );

    assign feed = (state_q == ST_FEED);
    assign wr   = (state_q == ST_WRITE);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

    // Address and data outputs are held at zero when not qualified.
    assign bus.w_ren   = feed;
    assign bus.d_ren   = feed;
    assign bus.w_addr  = feed ? w_addr_a : '0;
    assign bus.d_addr  = feed ? d_addr_a : '0;
    assign bus.mac_vld = vld_q;
    assign bus.mac_win = vld_q ? bus.w_rdata : '0;
    assign bus.mac_din = vld_q ? bus.d_rdata : '0;
    assign bus.o_we    = wr;
    assign bus.o_addr  = wr ? o_addr_a : '0;
    assign bus.o_wdata = wr ? res_q : '0;

endmodule
